// File: rtl/quant_issue_ctrl_if.sv
// Sample/result streams around the quantization flow controller: upstream
// prediction samples (s_*) in, FIFO head (m_*) out.
interface quant_issue_ctrl_if #(
  parameter int WIDTH     = 32,
  parameter int OUT_WIDTH = 2,
  parameter int QUANT     = 13
);
  logic                 s_valid;
  logic                 s_ready;
  logic [WIDTH-1:0]     s_error;
  logic [WIDTH-1:0]     s_pred;
  logic [OUT_WIDTH-1:0] s_encode;

  logic                 m_valid;
  logic                 m_ready;
  logic [QUANT:0]       m_quant_code;
  logic [WIDTH-1:0]     m_prediction;
  logic [OUT_WIDTH-1:0] m_encode;
  logic                 m_quantized;

  modport master (
    output s_valid, s_error, s_pred, s_encode, m_ready,
    input  s_ready, m_valid, m_quant_code, m_prediction, m_encode, m_quantized
  );

  modport slave (
    input  s_valid, s_error, s_pred, s_encode, m_ready,
    output s_ready, m_valid, m_quant_code, m_prediction, m_encode, m_quantized
  );
endinterface

// File: rtl/quant_issue_ctrl.sv
// Issue/credit controller for the fixed-latency quantization pipeline: tracks
// in-flight samples with a latency shift register and queues returns in a FIFO.
module quant_issue_ctrl #(
  parameter int WIDTH     = 32,
  parameter int OUT_WIDTH = 2,
  parameter int QUANT     = 13,
  parameter int LAT       = 49,
  parameter int DEPTH     = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  quant_issue_ctrl_if.slave            bus,
  output logic                         q_in_valid,
  output logic [WIDTH-1:0]             q_error,
  output logic [WIDTH-1:0]             q_predict,
  output logic [OUT_WIDTH-1:0]         q_encode,
  input  logic                         q_out_valid,
  input  logic [OUT_WIDTH-1:0]         q_encode_out,
  input  logic [QUANT:0]               q_quant_code,
  input  logic [WIDTH-1:0]             q_prediction_out,
  output logic [$clog2(DEPTH+1)-1:0]   inflight,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         busy,
  output logic                         err_sticky
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  typedef logic [AW-1:0] ptr_t;

  typedef struct packed {
    logic [QUANT:0]       quant;
    logic [WIDTH-1:0]     pred;
    logic [OUT_WIDTH-1:0] enc;
    logic                 quantized;
  } entry_t;

  entry_t         mem [DEPTH];
  ptr_t           wr_ptr;
  ptr_t           rd_ptr;
  logic [LAT-1:0] track_q;
  logic           tap;
  logic           accept;
  logic           pop;
  logic [CW:0]    committed;
  entry_t         wr_entry;
  entry_t         head;

  function automatic ptr_t ptr_next(ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  // Credit counts both in-flight and queued samples, so a return always has room.
  always_comb begin
    tap         = track_q[LAT-1];
    committed   = {1'b0, inflight} + {1'b0, level};
    bus.s_ready = rst & (committed < DEPTH_C);
    accept      = bus.s_valid & bus.s_ready;
    bus.m_valid = (level != '0);
    pop         = bus.m_valid & bus.m_ready;
    busy        = (inflight != '0) | (level != '0);
  end

  always_comb begin
    wr_entry.quant     = q_quant_code;
    wr_entry.pred      = q_prediction_out;
    wr_entry.enc       = q_out_valid ? q_encode_out : '0;
    wr_entry.quantized = q_out_valid;
  end

  // Head fields read as zero whenever the FIFO is empty, including during reset.
  always_comb begin
    head             = bus.m_valid ? mem[rd_ptr] : '0;
    bus.m_quant_code = head.quant;
    bus.m_prediction = head.pred;
    bus.m_encode     = head.enc;
    bus.m_quantized  = head.quantized;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_in_valid <= 1'b0;
      q_error    <= '0;
      q_predict  <= '0;
      q_encode   <= '0;
    end else begin
      q_in_valid <= accept;
      if (accept) begin
        q_error   <= bus.s_error;
        q_predict <= bus.s_pred;
        q_encode  <= bus.s_encode;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      track_q <= '0;
    end else begin
      track_q <= (track_q << 1) | LAT'(q_in_valid);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight <= '0;
    end else begin
      case ({accept, tap})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (tap) wr_ptr <= ptr_next(wr_ptr);
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      case ({tap, pop})
        2'b10:   level <= level + CW'(1);
        2'b01:   level <= level - CW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (tap) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_sticky <= 1'b0;
    end else if (q_out_valid && !tap) begin
      err_sticky <= 1'b1;
    end
  end
endmodule

// File: tb/tb_quant_issue_ctrl.sv
// Scoreboard bench for quant_issue_ctrl with a behavioural fixed-latency
// pipeline model and randomized sample data.
module tb_quant_issue_ctrl;
  localparam int WIDTH     = 32;
  localparam int OUT_WIDTH = 2;
  localparam int QUANT     = 13;
  localparam int LAT       = 49;
  localparam int DEPTH     = 64;
  localparam int CW        = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  quant_issue_ctrl_if #(.WIDTH(WIDTH), .OUT_WIDTH(OUT_WIDTH), .QUANT(QUANT)) bus ();

  logic                 q_in_valid;
  logic [WIDTH-1:0]     q_error;
  logic [WIDTH-1:0]     q_predict;
  logic [OUT_WIDTH-1:0] q_encode;
  logic                 q_out_valid = 1'b0;
  logic [OUT_WIDTH-1:0] q_encode_out = '0;
  logic [QUANT:0]       q_quant_code = '0;
  logic [WIDTH-1:0]     q_prediction_out = '0;
  logic [CW-1:0]        inflight;
  logic [CW-1:0]        level;
  logic                 busy;
  logic                 err_sticky;

  quant_issue_ctrl #(
    .WIDTH(WIDTH), .OUT_WIDTH(OUT_WIDTH), .QUANT(QUANT), .LAT(LAT), .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .q_in_valid(q_in_valid),
    .q_error(q_error),
    .q_predict(q_predict),
    .q_encode(q_encode),
    .q_out_valid(q_out_valid),
    .q_encode_out(q_encode_out),
    .q_quant_code(q_quant_code),
    .q_prediction_out(q_prediction_out),
    .inflight(inflight),
    .level(level),
    .busy(busy),
    .err_sticky(err_sticky)
  );

  typedef struct {
    logic [QUANT:0]       quant;
    logic [WIDTH-1:0]     pred;
    logic [OUT_WIDTH-1:0] enc;
    logic                 quantized;
  } res_t;

  typedef struct {
    int                   due;
    int                   seq;
    logic [WIDTH-1:0]     e;
    logic [WIDTH-1:0]     p;
    logic [OUT_WIDTH-1:0] enc;
  } pipe_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  res_t sb[$];
  bit   mon_en = 1'b0;
  int   drop_seq = -1;
  int   acc_seq = 0;
  int   ncyc = 0;
  int   mv_count = 0;
  int   mv_first = -1;
  int   mv_last = -1;
  int   unq_count = 0;
  bit   spur_req = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stand-in for the quantizer arithmetic; only needs to be data dependent.
  function automatic logic [QUANT:0] pipe_quant(input logic [WIDTH-1:0] e, input logic [WIDTH-1:0] p);
    logic [WIDTH-1:0] x;
    x = e ^ (p >> 3);
    return x[QUANT:0];
  endfunction

  function automatic res_t expect_of(input logic [WIDTH-1:0] e, input logic [WIDTH-1:0] p,
                                     input logic [OUT_WIDTH-1:0] enc, input bit quantized);
    res_t r;
    r.quant     = pipe_quant(e, p);
    r.pred      = e + p;
    r.enc       = quantized ? enc : '0;
    r.quantized = quantized;
    return r;
  endfunction

  // Pipeline model: a result appears exactly LAT cycles after its issue strobe.
  pipe_t pq[$];
  int    pcyc = 0;
  int    iss_seq = 0;
  always begin : pipeline_model
    pipe_t t;
    @(negedge clk);
    pcyc++;
    q_out_valid      = 1'b0;
    q_encode_out     = '0;
    q_quant_code     = '0;
    q_prediction_out = '0;
    if (pq.size() > 0 && pq[0].due == pcyc) begin
      t                = pq.pop_front();
      q_out_valid      = (t.seq != drop_seq);
      q_encode_out     = t.enc;
      q_quant_code     = pipe_quant(t.e, t.p);
      q_prediction_out = t.e + t.p;
    end else if (spur_req) begin
      q_out_valid      = 1'b1;
      q_encode_out     = 2'b11;
      q_quant_code     = '1;
      q_prediction_out = 32'hDEADBEEF;
      spur_req         = 1'b0;
    end
    if (q_in_valid === 1'b1) begin
      pq.push_back('{pcyc + LAT, iss_seq, q_error, q_predict, q_encode});
      iss_seq++;
    end
  end

  always begin : monitor
    res_t r;
    @(negedge clk);
    #1;
    ncyc++;
    if (mon_en) begin
      check("outstanding", 64'(inflight) + 64'(level), 64'(sb.size()));
      check("busy_vs_model", busy, (sb.size() != 0) ? 1 : 0);
      if (bus.m_valid === 1'b1) begin
        mv_count++;
        if (mv_first < 0) mv_first = ncyc;
        mv_last = ncyc;
      end
      if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
        check("output_expected", (sb.size() != 0) ? 1 : 0, 1);
        if (sb.size() != 0) begin
          r = sb.pop_front();
          check("m_quant_code", bus.m_quant_code, r.quant);
          check("m_prediction", bus.m_prediction, r.pred);
          check("m_encode", bus.m_encode, r.enc);
          check("m_quantized", bus.m_quantized, r.quantized);
          if (bus.m_quantized === 1'b0) unq_count++;
        end
      end
      if (bus.s_valid === 1'b1 && bus.s_ready === 1'b1) begin
        sb.push_back(expect_of(bus.s_error, bus.s_pred, bus.s_encode, acc_seq != drop_seq));
        acc_seq++;
      end
    end
  end

  task automatic drive_rand();
    bus.s_valid  = 1'b1;
    bus.s_error  = $urandom;
    bus.s_pred   = $urandom;
    bus.s_encode = OUT_WIDTH'($urandom_range(1, 3));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_s_ready"}, bus.s_ready, 0);
    check({tag, "_m_valid"}, bus.m_valid, 0);
    check({tag, "_m_quant_code"}, bus.m_quant_code, 0);
    check({tag, "_m_prediction"}, bus.m_prediction, 0);
    check({tag, "_m_encode"}, bus.m_encode, 0);
    check({tag, "_m_quantized"}, bus.m_quantized, 0);
    check({tag, "_q_in_valid"}, q_in_valid, 0);
    check({tag, "_q_error"}, q_error, 0);
    check({tag, "_q_predict"}, q_predict, 0);
    check({tag, "_q_encode"}, q_encode, 0);
    check({tag, "_inflight"}, inflight, 0);
    check({tag, "_level"}, level, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err_sticky"}, err_sticky, 0);
  endtask

  initial begin : watchdog
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int accepts;
    int drops;
    int late;
    bus.s_valid  = 1'b0;
    bus.s_error  = '0;
    bus.s_pred   = '0;
    bus.s_encode = '0;
    bus.m_ready  = 1'b0;

    // Reset state
    #12;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("s_ready_after_reset", bus.s_ready, 1);
    mon_en = 1'b1;

    // Single sample: latency and inflight window
    @(negedge clk);
    bus.s_valid  = 1'b1;
    bus.s_error  = 32'h3A83126F;
    bus.s_pred   = 32'h3F800000;
    bus.s_encode = 2'b01;
    @(negedge clk);
    bus.s_valid = 1'b0;
    for (int n = 1; n <= LAT + 2; n++) begin
      if (n > 1) @(negedge clk);
      if (n == LAT + 2) bus.m_ready = 1'b1;
      #1;
      check("single_q_in_valid", q_in_valid, (n == 1) ? 1 : 0);
      check("single_inflight", inflight, (n <= LAT + 1) ? 1 : 0);
      check("single_m_valid", bus.m_valid, (n == LAT + 2) ? 1 : 0);
    end
    @(negedge clk);
    bus.m_ready = 1'b0;
    #1;
    check("single_level_after_pop", level, 0);

    // Back-to-back stream with m_ready held high
    mv_count = 0;
    mv_first = -1;
    mv_last  = -1;
    drops    = 0;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      drive_rand();
      #1;
      if (bus.s_ready !== 1'b1) drops++;
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
    for (int n = 1; n <= LAT + 3; n++) begin
      if (n > 1) @(negedge clk);
      #1;
      if (n == LAT + 2) check("stream_busy_last", busy, 1);
      if (n == LAT + 3) check("stream_busy_clear", busy, 0);
    end
    check("stream_ready_drops", drops, 0);
    check("stream_out_count", mv_count, 200);
    check("stream_contiguous", mv_last - mv_first + 1, 200);

    // Unquantizable return for the fourth sample of a burst
    unq_count = 0;
    @(negedge clk);
    drop_seq = acc_seq + 3;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      drive_rand();
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
    repeat (LAT + 12) @(negedge clk);
    #1;
    check("drop_unquantized_count", unq_count, 1);
    check("drop_err_sticky", err_sticky, 0);
    drop_seq = -1;

    // Backpressure: credit limits accepts to DEPTH
    bus.m_ready = 1'b0;
    accepts = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      drive_rand();
      #1;
      if (bus.s_ready === 1'b1) accepts++;
    end
    check("bp_accepts", accepts, DEPTH);
    check("bp_s_ready_low", bus.s_ready, 0);
    check("bp_committed", 64'(inflight) + 64'(level), DEPTH);
    check("bp_level_full", level, DEPTH);
    @(negedge clk);
    bus.m_ready = 1'b1;
    drive_rand();
    @(negedge clk);
    bus.m_ready = 1'b0;
    accepts = 0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      drive_rand();
      #1;
      if (bus.s_ready === 1'b1) accepts++;
    end
    check("bp_single_credit", accepts, 1);
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #1;
      if (busy === 1'b0) break;
    end
    check("bp_drain_timeout", busy, 0);

    // Spurious pipeline result with nothing outstanding
    @(negedge clk);
    #2;
    check("spur_err_before", err_sticky, 0);
    spur_req = 1'b1;
    @(negedge clk);
    #1;
    check("spur_presented", q_out_valid, 1);
    @(negedge clk);
    #1;
    check("spur_level", level, 0);
    check("spur_err_set", err_sticky, 1);
    repeat (10) @(negedge clk);
    #1;
    check("spur_err_held", err_sticky, 1);

    // Reset with 30 in flight and 10 queued
    bus.m_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive_rand();
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
    repeat (9) @(negedge clk);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      drive_rand();
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (level === CW'(10)) break;
      @(negedge clk);
    end
    check("rst_level_reached", level, 10);
    check("rst_inflight_30", inflight, 30);
    mon_en = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    check_all_zero("midrst");
    sb.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_s_ready_after", bus.s_ready, 1);
    bus.m_ready = 1'b1;
    late = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      #1;
      if (level !== '0 || bus.m_valid !== 1'b0) late++;
    end
    check("rst_late_results_dropped", late, 0);
    check("rst_inflight_after", inflight, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
